// File: rtl/ltc2308_spi_ctrl.sv
// Conversion/SPI frame controller for the LTC2308 ADC: CONVST pulse, conversion
// wait, then a 12-bit full-duplex shift that returns the previous frame's sample.
module ltc2308_spi_ctrl #(
  parameter int CLK_DIV       = 2,
  parameter int CONVST_CYCLES = 2,
  parameter int CONV_CYCLES   = 80
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  ch,
  output logic        busy,
  output logic        done,
  output logic [11:0] data,
  output logic [2:0]  data_ch,
  output logic        data_valid,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo
);

  localparam int CW = 16;

  typedef enum logic [2:0] {IDLE, CONV_PULSE, CONV_WAIT, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    bit_q, bit_d;
  logic [5:0]    cfg_q, cfg_d;
  logic [2:0]    cur_ch_q, cur_ch_d;
  logic [2:0]    prev_ch_q, prev_ch_d;
  logic          have_prev_q, have_prev_d;
  logic [11:0]   sr_q, sr_d;
  logic [11:0]   data_q, data_d;
  logic [2:0]    data_ch_q, data_ch_d;
  logic          valid_q, valid_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      bit_q       <= '0;
      cfg_q       <= '0;
      cur_ch_q    <= '0;
      prev_ch_q   <= '0;
      have_prev_q <= 1'b0;
      sr_q        <= '0;
      data_q      <= '0;
      data_ch_q   <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      cfg_q       <= cfg_d;
      cur_ch_q    <= cur_ch_d;
      prev_ch_q   <= prev_ch_d;
      have_prev_q <= have_prev_d;
      sr_q        <= sr_d;
      data_q      <= data_d;
      data_ch_q   <= data_ch_d;
      valid_q     <= valid_d;
    end
  end

  // Results are published on entry to DONE so they appear together with done.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    cfg_d       = cfg_q;
    cur_ch_d    = cur_ch_q;
    prev_ch_d   = prev_ch_q;
    have_prev_d = have_prev_q;
    sr_d        = sr_q;
    data_d      = data_q;
    data_ch_d   = data_ch_q;
    valid_d     = valid_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d  = CONV_PULSE;
          cnt_d    = '0;
          cur_ch_d = ch;
          cfg_d    = {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
        end
      end
      CONV_PULSE: begin
        if (cnt_q == CW'(CONVST_CYCLES - 1)) begin
          state_d = CONV_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CONV_WAIT: begin
        if (cnt_q == CW'(CONV_CYCLES - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
          sr_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            sr_d    = {sr_q[10:0], adc_sdo};
          end else begin
            phase_d = 1'b0;
            if (bit_q == 4'd11) begin
              state_d     = DONE;
              data_d      = sr_q;
              data_ch_d   = prev_ch_q;
              valid_d     = have_prev_q;
              prev_ch_d   = cur_ch_q;
              have_prev_d = 1'b1;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // SDI carries the 6-bit config word MSB first over the first six SCK periods.
  always_comb begin
    busy       = (state_q == CONV_PULSE) || (state_q == CONV_WAIT) || (state_q == SHIFT);
    done       = (state_q == DONE);
    adc_convst = (state_q == CONV_PULSE);
    adc_sck    = (state_q == SHIFT) && phase_q;
    adc_sdi    = 1'b0;
    if ((state_q == SHIFT) && (bit_q < 4'd6)) begin
      adc_sdi = cfg_q[3'd5 - bit_q[2:0]];
    end
    data       = data_q;
    data_ch    = data_ch_q;
    data_valid = valid_q;
  end

endmodule

// File: tb/tb_ltc2308_spi_ctrl.sv
// Self-checking bench for ltc2308_spi_ctrl: an ADC model drives SDO and a
// channel-tag / config-word reference model checks every frame.
`timescale 1ns/1ps
module tb_ltc2308_spi_ctrl;

  localparam int LAT = 2 + 80 + 24 * 2 + 1;
  localparam int T_CLK_DIV = 3;
  localparam int T_CONVST  = 3;
  localparam int T_CONV    = 10;
  localparam int T_LAT     = T_CONVST + T_CONV + 24 * T_CLK_DIV + 1;
  localparam logic [2:0] CH_MAP [8] = '{3'b000, 3'b100, 3'b001, 3'b101,
                                        3'b010, 3'b110, 3'b011, 3'b111};

  logic clock = 1'b0;
  logic reset_n, start, sdo;
  logic [2:0] ch;
  logic busy, done, dataValid, adcConvst, adcSck, adcSdi;
  logic [11:0] data;
  logic [2:0] dataCh;

  logic start3, sdo3;
  logic [2:0] ch3;
  logic busy3, done3, dataValid3, adcConvst3, adcSck3, adcSdi3;
  logic [11:0] data3;
  logic [2:0] dataCh3;

  int vectors = 0;
  int miscompares = 0;
  int violations = 0;
  logic [2:0] prevChM = 3'd0;
  logic havePrevM = 1'b0;
  logic [11:0] frameWord = 12'h000;
  logic [11:0] sdiCap = 12'h000;
  int nRise = 0;
  logic sckPrev = 1'b0;

  ltc2308_spi_ctrl dut (
    .clock(clock), .reset_n(reset_n), .start(start), .ch(ch),
    .busy(busy), .done(done), .data(data), .data_ch(dataCh), .data_valid(dataValid),
    .adc_convst(adcConvst), .adc_sck(adcSck), .adc_sdi(adcSdi), .adc_sdo(sdo)
  );

  ltc2308_spi_ctrl #(.CLK_DIV(T_CLK_DIV), .CONVST_CYCLES(T_CONVST), .CONV_CYCLES(T_CONV)) dut3 (
    .clock(clock), .reset_n(reset_n), .start(start3), .ch(ch3),
    .busy(busy3), .done(done3), .data(data3), .data_ch(dataCh3), .data_valid(dataValid3),
    .adc_convst(adcConvst3), .adc_sck(adcSck3), .adc_sdi(adcSdi3), .adc_sdo(sdo3)
  );

  always #5 clock = ~clock;

  // ADC model: presents the frame word MSB first, advancing after each SCK rise.
  always @(posedge clock) begin
    #1;
    if (adcConvst) begin
      nRise = 0;
      sdo = frameWord[11];
      sdiCap = '0;
    end else if (adcSck && !sckPrev) begin
      sdiCap = {sdiCap[10:0], adcSdi};
      nRise++;
      sdo = (nRise < 12) ? frameWord[11 - nRise] : 1'b0;
    end
    if ((adcSck || adcConvst) && !busy) violations++;
    if (adcSck && adcConvst) violations++;
    sckPrev = adcSck;
  end

  function automatic logic [11:0] expSdi(input logic [2:0] c);
    return {1'b1, CH_MAP[c], 1'b1, 1'b0, 6'b0};
  endfunction

  task automatic runFrame(input logic [2:0] c, input logic [11:0] w, input string name);
    int lat;
    bit got;
    @(negedge clock);
    start = 1'b1; ch = c; frameWord = w;
    lat = 0; got = 0;
    for (int i = 1; i <= 1000 && !got; i++) begin
      @(negedge clock);
      start = 1'b0; ch = 3'($urandom);
      lat = i;
      if (done) got = 1;
    end
    vectors++;
    if (!got || lat != LAT) begin
      miscompares++; $display("[TB] FAIL %s latency: got %0d expected %0d", name, got ? lat : -1, LAT);
    end
    vectors++;
    if (data !== w) begin
      miscompares++; $display("[TB] FAIL %s data: got %h expected %h", name, data, w);
    end
    vectors++;
    if (dataCh !== prevChM || dataValid !== havePrevM) begin
      miscompares++;
      $display("[TB] FAIL %s tag: got ch=%0d valid=%b expected ch=%0d valid=%b", name, dataCh, dataValid, prevChM, havePrevM);
    end
    vectors++;
    if (sdiCap !== expSdi(c)) begin
      miscompares++; $display("[TB] FAIL %s sdi: got %b expected %b", name, sdiCap, expSdi(c));
    end
    prevChM = c; havePrevM = 1'b1;
    @(negedge clock);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || data !== w) begin
      miscompares++; $display("[TB] FAIL %s after-done: got done=%b busy=%b data=%h expected 0 0 %h", name, done, busy, data, w);
    end
  endtask

  task automatic applyResetState();
    vectors++;
    if ({busy, done, data, dataCh, dataValid, adcConvst, adcSck, adcSdi} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %h expected 0", {busy, done, data, dataCh, dataValid, adcConvst, adcSck, adcSdi});
    end
  endtask

  task automatic test_first_frame();
    runFrame(3'd5, 12'hA5C, "first_frame");
  endtask

  task automatic test_tag_pipeline();
    runFrame(3'd2, 12'h3F1, "tag_second");
    runFrame(3'd7, 12'($urandom), "tag_third");
  endtask

  task automatic test_reset_mid_frame();
    bit inShift;
    int badIdle;
    @(negedge clock);
    start = 1'b1; ch = 3'($urandom); frameWord = 12'($urandom);
    inShift = 0;
    for (int i = 0; i < 300 && !inShift; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (adcSck) inShift = 1;
    end
    vectors++;
    if (!inShift) begin
      miscompares++; $display("[TB] FAIL reset_reach_shift: got sck=0 expected sck=1");
    end
    #2 reset_n = 1'b0;
    #1 applyResetState();
    @(negedge clock);
    @(negedge clock) reset_n = 1'b1;
    prevChM = 3'd0; havePrevM = 1'b0;
    badIdle = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (busy !== 1'b0 || adcSck !== 1'b0 || adcConvst !== 1'b0) badIdle++;
    end
    vectors++;
    if (badIdle != 0) begin
      miscompares++; $display("[TB] FAIL reset_idle_hold: got %0d active cycles expected 0", badIdle);
    end
    runFrame(3'($urandom), 12'($urandom), "post_reset_frame");
  endtask

  task automatic test_channel_sweep();
    for (int c = 0; c < 8; c++) runFrame(3'(c), 12'($urandom), "channel_sweep");
  endtask

  task automatic test_busy_rules();
    int dones, rises;
    logic prevConvst;
    logic [11:0] w;
    w = 12'($urandom);
    @(negedge clock);
    start = 1'b1; ch = 3'd3; frameWord = w;
    dones = 0; rises = 0; prevConvst = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clock);
      start = (i < 120) && (i % 7 == 0);
      ch = 3'($urandom);
      if (done) begin
        dones++;
        vectors++;
        if (data !== w) begin
          miscompares++; $display("[TB] FAIL busy_data: got %h expected %h", data, w);
        end
      end
      if (adcConvst && !prevConvst) rises++;
      prevConvst = adcConvst;
    end
    start = 1'b0;
    vectors++;
    if (dones != 1 || rises != 1) begin
      miscompares++; $display("[TB] FAIL busy_single_frame: got dones=%0d frames=%0d expected 1 1", dones, rises);
    end
    prevChM = 3'd3; havePrevM = 1'b1;
    runFrame(3'($urandom), 12'($urandom), "after_busy_tag");
  endtask

  task automatic test_back_to_back();
    logic [2:0] chs [3];
    logic [11:0] ws [3];
    int lat;
    bit got;
    for (int f = 0; f < 3; f++) begin
      chs[f] = 3'($urandom); ws[f] = 12'($urandom);
    end
    @(negedge clock);
    start = 1'b1; ch = chs[0]; frameWord = ws[0];
    for (int f = 0; f < 3; f++) begin
      got = 0; lat = 0;
      for (int i = 1; i <= 1000 && !got; i++) begin
        @(negedge clock);
        lat = i;
        if (f > 0 && i == 1) begin
          vectors++;
          if (busy !== 1'b1) begin
            miscompares++; $display("[TB] FAIL b2b_busy: got %b expected 1", busy);
          end
        end
        if (done) got = 1;
      end
      vectors++;
      if (!got || lat != LAT) begin
        miscompares++; $display("[TB] FAIL b2b_latency: got %0d expected %0d", got ? lat : -1, LAT);
      end
      vectors++;
      if (data !== ws[f] || dataCh !== prevChM || dataValid !== havePrevM) begin
        miscompares++;
        $display("[TB] FAIL b2b_result: got %h/%0d/%b expected %h/%0d/%b", data, dataCh, dataValid, ws[f], prevChM, havePrevM);
      end
      prevChM = chs[f]; havePrevM = 1'b1;
      if (f < 2) begin
        ch = chs[f + 1]; frameWord = ws[f + 1];
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clock);
  endtask

  task automatic test_timing();
    int convHigh, fallIdx, firstRise, doneIdx, runLen, badRuns;
    logic prev3;
    int runs [$];
    @(negedge clock);
    start3 = 1'b1; ch3 = 3'($urandom);
    convHigh = 0; fallIdx = -1; firstRise = -1; doneIdx = -1; runLen = 0; prev3 = 1'b0;
    for (int i = 1; i <= 400 && doneIdx < 0; i++) begin
      @(negedge clock);
      start3 = 1'b0;
      if (adcConvst3) convHigh++;
      else if (convHigh > 0 && fallIdx < 0) fallIdx = i;
      if (adcSck3 !== prev3) begin
        if (firstRise >= 0) runs.push_back(runLen);
        if (adcSck3 && firstRise < 0) firstRise = i;
        runLen = 0;
      end
      runLen++;
      prev3 = adcSck3;
      if (done3) doneIdx = i;
    end
    badRuns = 0;
    foreach (runs[k]) if (runs[k] != T_CLK_DIV) badRuns++;
    vectors++;
    if (convHigh != T_CONVST) begin
      miscompares++; $display("[TB] FAIL timing_convst: got %0d expected %0d", convHigh, T_CONVST);
    end
    vectors++;
    if (firstRise - fallIdx != T_CONV + T_CLK_DIV) begin
      miscompares++; $display("[TB] FAIL timing_gap: got %0d expected %0d", firstRise - fallIdx, T_CONV + T_CLK_DIV);
    end
    vectors++;
    if (runs.size() != 23 || badRuns != 0) begin
      miscompares++; $display("[TB] FAIL timing_sck: got %0d phases %0d bad expected 23 phases 0 bad", runs.size(), badRuns);
    end
    vectors++;
    if (doneIdx != T_LAT) begin
      miscompares++; $display("[TB] FAIL timing_latency: got %0d expected %0d", doneIdx, T_LAT);
    end
    vectors++;
    if (data3 !== 12'hFFF || dataValid3 !== 1'b0) begin
      miscompares++; $display("[TB] FAIL timing_data: got %h/%b expected fff/0", data3, dataValid3);
    end
  endtask

  task automatic checkOutput();
    vectors++;
    if (violations != 0) begin
      miscompares++; $display("[TB] FAIL strobe_invariants: got %0d violations expected 0", violations);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; ch = 3'd0; sdo = 1'b0;
    start3 = 1'b0; ch3 = 3'd0; sdo3 = 1'b1;
    repeat (3) @(negedge clock);
    applyResetState();
    reset_n = 1'b1;
    @(negedge clock);
    test_first_frame();
    test_tag_pipeline();
    test_reset_mid_frame();
    test_channel_sweep();
    test_busy_rules();
    test_back_to_back();
    test_timing();
    checkOutput();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ltc2308_spi_ctrl.md
Name: ltc2308_spi_ctrl

Overview:
SPI conversion controller for the LTC2308 8-channel 12-bit ADC on the DE1-SoC. It sits directly upstream of the ADC capture FIFO. On each start request it runs one conversion frame: CONVST pulse, conversion wait, then a 12-bit full-duplex shift. It returns the sample with a tag for the channel the sample belongs to. It replaces the vendor ADC core behind the capture FIFO's measure_start / measure_done handshake.

Parameters:
CLK_DIV, 2, clock cycles per SCK half-period (>=1); SCK = clock/(2*CLK_DIV), must be <=40 MHz
CONVST_CYCLES, 2, clock cycles CONVST held high (>=1)
CONV_CYCLES, 80, clock cycles CONVST low before first SCK (>=tCONV, 1.6 us at 50 MHz)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  frame request, sampled only when busy=0
ch  in  3  single-ended channel for next conversion, latched with start
busy  out  1  high from cycle after start accepted until done cycle
done  out  1  one-cycle pulse, data/data_ch/data_valid updated same cycle
data  out  12  last sample read, MSB first from SDO
data_ch  out  3  channel the data belongs to
data_valid  out  1  0 if frame carried no prior config (first frame after reset)
adc_convst  out  1  LTC2308 CONVST
adc_sck  out  1  LTC2308 SCK
adc_sdi  out  1  LTC2308 SDI
adc_sdo  in  1  LTC2308 SDO

Behaviour:
- Reset (async, any state): all outputs 0. FSM goes to IDLE. Shift registers cleared. have_prev=0, prev_ch=0.
- FSM: IDLE -> CONV_PULSE -> CONV_WAIT -> SHIFT -> DONE -> IDLE.
- IDLE: busy=0. On start=1, latch ch into cur_ch and load the 6-bit config word {S/D=1, O/S=ch[0], S1=ch[2], S0=ch[1], UNI=1, SLP=0}. Go to CONV_PULSE.
- CONV_PULSE: adc_convst=1 for CONVST_CYCLES cycles.
- CONV_WAIT: adc_convst=0 for CONV_CYCLES cycles. adc_sck=0.
- SHIFT: 12 SCK periods, each CLK_DIV cycles low then CLK_DIV cycles high.
  - adc_sdi holds config bit k (MSB first) during the low phase and the high phase of period k, for k=0..5. adc_sdi=0 for periods 6..11.
  - adc_sdo is sampled on the clock edge at which adc_sck rises. Shift left into data_sr.
  - After the 12th high phase, adc_sck returns to 0 and the FSM enters DONE.
- DONE (1 cycle): done=1, busy=0.
  - data<=data_sr, data_ch<=prev_ch, data_valid<=have_prev.
  - Then prev_ch<=cur_ch, have_prev<=1.
  - Next state IDLE. If start=1 in this cycle, it is accepted as if in IDLE (back-to-back frames).
- Pipeline rule: LTC2308 returns the result of the conversion configured in the previous frame. data_ch therefore always equals the ch of the prior accepted start.
- Latency: start sampled at edge E0 -> done high at E0 + CONVST_CYCLES + CONV_CYCLES + 24*CLK_DIV + 1. Defaults give 131 cycles.
- start while busy=1: ignored, no queuing. ch changes during busy: ignored.
- data/data_ch/data_valid hold their values between done pulses.
- Reset mid-frame: outputs drop immediately. The next frame after reset reports data_valid=0.
- adc_sck is never high outside SHIFT. adc_convst is never high outside CONV_PULSE.

Test Plan:
- Reset: assert reset_n=0 mid-SHIFT -> all outputs 0 same cycle. After release, busy=0 and adc_sck=0 hold indefinitely with start=0.
- First frame: start=1 with ch=5, SDO model returns 0xA5C -> SDI bits 1,1,1,0,1,0 then 0s. done at exactly 131 cycles after start sample. data=0xA5C, data_valid=0.
- Tag pipeline: second frame with ch=2, model returns 0x3F1 -> data=0x3F1, data_ch=5, data_valid=1. SDI bits 1,0,0,1,1,0. Third frame ch=7 -> data_ch=2.
- Timing: CLK_DIV=3 -> each SCK half-period is exactly 3 cycles. CONVST high exactly CONVST_CYCLES. Gap from CONVST fall to first SCK rise is exactly CONV_CYCLES+CLK_DIV cycles.
- Busy rules: pulse start repeatedly during busy -> exactly one frame runs. Hold start=1 continuously -> a new frame begins on each done cycle, with busy high again the next cycle.
- Channel map: sweep ch=0..7 -> O/S,S1,S0 = 000,100,001,101,010,110,011,111.
